axis_hdr_arbiter: RTL

AXIS_HDR_ARBITER -- requirements
Module: axis_hdr_arbiter

---
 rtl/axis_hdr_pkg.sv | 13 +
 rtl/axis_hdr_arbiter_rr_arb.sv | 29 ++
 rtl/axis_hdr_arbiter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/axis_hdr_pkg.sv
// Shared definitions for the AXI-Stream header arbiter: packet counter width and FSM encoding.
package axis_hdr_pkg;

    localparam int unsigned PKT_CNT_WD = 16;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StHdr   = 2'd1,
        StPay   = 2'd2,
        StDrain = 2'd3
    } state_e;

endpackage

// File: rtl/axis_hdr_arbiter_rr_arb.sv
// Combinational round-robin picker: first requester at or after ptr, ascending with wrap.
module rr_arb
    import axis_hdr_pkg::*;
#(
    parameter int N      = 2,
    parameter int PTR_WD = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]      req,
    input  logic [PTR_WD-1:0] ptr,
    output logic [N-1:0]      gnt,
    output logic              valid
);

    // Scan from the farthest distance down so the closest requester is written last and wins.
    always_comb begin
        gnt = '0;
        for (int d = N - 1; d >= 0; d--) begin
            for (int j = 0; j < N; j++) begin
                if (req[j] && (((j + N - int'(ptr)) % N) == d)) begin
                    gnt    = '0;
                    gnt[j] = 1'b1;
                end
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/axis_hdr_arbiter.sv
// Grants one of NUM_SRC header+payload sources to a single insert engine, one packet at a time.
module axis_hdr_arbiter
    import axis_hdr_pkg::*;
#(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
    parameter int NUM_SRC      = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_SRC-1:0]              s_valid_insert,
    output logic [NUM_SRC-1:0]              s_ready_insert,
    input  logic [NUM_SRC*DATA_WD-1:0]      s_data_insert,
    input  logic [NUM_SRC*DATA_BYTE_WD-1:0] s_keep_insert,
    input  logic [NUM_SRC*BYTE_CNT_WD-1:0]  s_byte_insert_cnt,
    input  logic [NUM_SRC-1:0]              s_valid_in,
    input  logic [NUM_SRC-1:0]              s_last_in,
    output logic [NUM_SRC-1:0]              s_ready_in,
    input  logic [NUM_SRC*DATA_WD-1:0]      s_data_in,
    input  logic [NUM_SRC*DATA_BYTE_WD-1:0] s_keep_in,
    output logic                            m_valid_insert,
    output logic [DATA_WD-1:0]              m_data_insert,
    output logic [DATA_BYTE_WD-1:0]         m_keep_insert,
    output logic [BYTE_CNT_WD-1:0]          m_byte_insert_cnt,
    input  logic                            m_ready_insert,
    output logic                            m_valid_in,
    output logic [DATA_WD-1:0]              m_data_in,
    output logic [DATA_BYTE_WD-1:0]         m_keep_in,
    output logic                            m_last_in,
    input  logic                            m_ready_in,
    input  logic                            eng_done,
    output logic [NUM_SRC-1:0]              grant,
    output logic                            busy,
    output logic [15:0]                     pkt_cnt
);

    localparam int PTR_WD = $clog2(NUM_SRC);

    state_e                  state_q, state_d;
    logic [NUM_SRC-1:0]      grant_q, grant_d;
    logic [PTR_WD-1:0]       rr_ptr_q, rr_ptr_d;
    logic [PKT_CNT_WD-1:0]   pkt_cnt_q, pkt_cnt_d;

    logic [NUM_SRC-1:0]      arb_gnt;
    logic                    arb_valid;
    logic [PTR_WD-1:0]       g_idx;
    logic                    sel_vins, sel_vin, sel_last;
    logic [DATA_WD-1:0]      sel_dins, sel_din;
    logic [DATA_BYTE_WD-1:0] sel_kins, sel_kin;
    logic [BYTE_CNT_WD-1:0]  sel_cnt;
    logic                    hdr_st, pay_st;

    rr_arb #(
        .N      (NUM_SRC),
        .PTR_WD (PTR_WD)
    ) u_rr_arb (
        .req   (s_valid_insert),
        .ptr   (rr_ptr_q),
        .gnt   (arb_gnt),
        .valid (arb_valid)
    );

    // One-hot grant selects the owner's slices; all-zero grant selects nothing.
    always_comb begin
        g_idx    = '0;
        sel_vins = 1'b0;
        sel_vin  = 1'b0;
        sel_last = 1'b0;
        sel_dins = '0;
        sel_din  = '0;
        sel_kins = '0;
        sel_kin  = '0;
        sel_cnt  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_q[i]) begin
                g_idx    = PTR_WD'(i);
                sel_vins = s_valid_insert[i];
                sel_vin  = s_valid_in[i];
                sel_last = s_last_in[i];
                sel_dins = s_data_insert[i*DATA_WD +: DATA_WD];
                sel_din  = s_data_in[i*DATA_WD +: DATA_WD];
                sel_kins = s_keep_insert[i*DATA_BYTE_WD +: DATA_BYTE_WD];
                sel_kin  = s_keep_in[i*DATA_BYTE_WD +: DATA_BYTE_WD];
                sel_cnt  = s_byte_insert_cnt[i*BYTE_CNT_WD +: BYTE_CNT_WD];
            end
        end
    end

    assign hdr_st = (state_q == StHdr);
    assign pay_st = (state_q == StPay);

    assign m_valid_insert    = hdr_st & sel_vins;
    assign m_data_insert     = m_valid_insert ? sel_dins : '0;
    assign m_keep_insert     = m_valid_insert ? sel_kins : '0;
    assign m_byte_insert_cnt = m_valid_insert ? sel_cnt : '0;
    assign s_ready_insert    = hdr_st ? (grant_q & {NUM_SRC{m_ready_insert}}) : '0;

    assign m_valid_in = pay_st & sel_vin;
    assign m_data_in  = m_valid_in ? sel_din : '0;
    assign m_keep_in  = m_valid_in ? sel_kin : '0;
    assign m_last_in  = m_valid_in & sel_last;
    assign s_ready_in = pay_st ? (grant_q & {NUM_SRC{m_ready_in}}) : '0;

    assign grant   = grant_q;
    assign busy    = (state_q != StIdle);
    assign pkt_cnt = pkt_cnt_q;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        pkt_cnt_d = pkt_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (arb_valid) begin
                    state_d = StHdr;
                    grant_d = arb_gnt;
                end
            end
            StHdr: begin
                if (m_valid_insert && m_ready_insert) state_d = StPay;
            end
            StPay: begin
                if (m_valid_in && m_ready_in && m_last_in) state_d = StDrain;
            end
            StDrain: begin
                // Only completion seen while already draining closes the packet.
                if (eng_done) begin
                    state_d   = StIdle;
                    grant_d   = '0;
                    pkt_cnt_d = pkt_cnt_q + 1'b1;
                    rr_ptr_d  = (g_idx == PTR_WD'(NUM_SRC - 1)) ? '0 : g_idx + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            pkt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

endmodule
